hazard_sb: RTL and testbench
============================

Name: hazard_sb

Overview:
- Next-generation hazard unit for the five-stage pipeline (F/D/E/M/W). Register-file width is parametrised.
- Replaces the external divider stall input with an internal multi-cycle divide sequencer (FSM plus latency counter).
- Adds memory-wait stalls and precise exception flush.
- Sits beside the datapath. Consumes register indices and control bits per stage; drives forward selects and per-stage stall/flush.

Parameters:
- AW, 5: register index width (2^AW architectural registers; index 0 hard-wired zero).
- DIV_LAT, 32: cycles the divider needs after start; legal range 1..255.
- CW, 8: divide counter width; must satisfy 2^CW > DIV_LAT.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous, active-high reset
- rsD, rtD  in  AW  D-stage source indices
- branchD  in  1  branch in D (compare uses forwardaD/forwardbD)
- rsE, rtE, writeregE  in  AW  E-stage indices
- regwriteE, memtoregE  in  1  E-stage write / load
- divE  in  1  divide/modulo instruction valid in E
- writeregM  in  AW;  regwriteM, memtoregM  in  1  M-stage controls
- jumpbranchM  in  1  taken jump/branch redirect resolved in M
- memstallM  in  1  data memory not ready
- exceptM  in  1  exception taken in M
- writeregW  in  AW;  regwriteW  in  1  W-stage controls
- forwardaD, forwardbD  out  1  M→D forward for the branch compare
- forwardaE, forwardbE  out  2  00 regfile, 01 from W, 10 from M
- stallF, stallD, stallE, stallM, stallW  out  1  per-stage stalls
- flushF, flushD, flushE, flushM, flushW  out  1  per-stage flushes
- divbusy  out  1  sequencer in BUSY
- divdoneE  out  1  divider result valid this cycle

Behaviour:
- Forwarding is combinational.
  - forwardaD = rsD≠0 & rsD==writeregM & regwriteM; forwardbD is the same using rtD.
  - forwardaE: M match → 10, else W match → 01, else 00. A match requires index≠0, index equality, and the stage's regwrite. M has priority over W.
- Load-use stall: lwstall = memtoregE & regwriteE & writeregE≠0 & (writeregE==rsD | writeregE==rtD).
- Divide sequencer states: IDLE, BUSY, DONE. Counter cnt is CW bits.
  - IDLE: if divE & ~exceptM, load cnt=DIV_LAT-1 and go to BUSY.
  - BUSY: if cnt==0 go to DONE, else decrement cnt.
  - DONE: divdoneE=1. Return to IDLE when memstallM=0; otherwise hold in DONE.
  - exceptM in any state: next state IDLE, cnt=0.
  - divstall = (IDLE & divE & ~exceptM) | BUSY.
  - Timing: divE first seen at cycle t → divstall high for cycles t..t+DIV_LAT; divdoneE high at t+DIV_LAT+1.
  - The counter keeps counting during memstallM.
- Output priority, highest first: exceptM, memstallM, divstall, lwstall, jumpbranchM.
  - exceptM: flushF, flushD, flushE, flushM = 1; all stalls = 0.
  - memstallM: stallF, stallD, stallE, stallM = 1; flushW = 1; no other flush.
  - divstall: stallF, stallD, stallE = 1; flushM = 1. A simultaneous jumpbranchM still asserts flushF and flushD, but not flushE.
  - lwstall: stallF, stallD = 1; flushE = 1. jumpbranchM additionally asserts flushD.
  - jumpbranchM alone: flushF, flushD, flushE = 1.
- stallW is constant 0.
- Reset: state=IDLE, cnt=0. divbusy=0 and divdoneE=0 in the reset cycle. The combinational outputs follow their input equations.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- When defined, adds four 32-bit outputs: perf_lw, perf_div, perf_mem, perf_flush.
  - Each counts cycles in which its condition wins the priority ordering.
  - Counters saturate at 0xFFFFFFFF and clear on rst.
- When undefined, these ports and registers do not exist. All other behaviour is identical.

Decomposition:
- hazard_pkg holds:
  - forward-select constants FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10;
  - the div FSM state encoding (IDLE=0, BUSY=1, DONE=2).
- Sub-module hazard_div_seq holds the FSM and counter.
  - Inputs: clk, rst, divE, exceptM, memstallM.
  - Outputs: divstall, divbusy, divdoneE.
- Forwarding and priority logic stay in the top module.

Test Plan:
- regwriteM=1, writeregM=8, rsE=8; regwriteW=1, writeregW=8 → forwardaE=10. Repeat with writeregM=0 and rsE=0 → forwardaE=00.
- memtoregE=1, regwriteE=1, writeregE=9, rtD=9 → stallF=stallD=flushE=1 for one cycle. With writeregE=0 → no stall.
- DIV_LAT=4, divE high from cycle 10 → stallE high cycles 10..14, divdoneE at 15, flushM high 10..14, state IDLE at 16.
- DIV_LAT=4, divE at cycle 10, exceptM at cycle 12 → flushF/D/E/M=1 at 12, divbusy=0 at 13, no divdoneE.
- Sequencer enters DONE at cycle 15 with memstallM high cycles 15..17 → divdoneE held 15..17, stallM=flushW=1, no restart at 18.
- rst asserted mid-BUSY (cnt=2) → next cycle divbusy=0, divdoneE=0. With HAZARD_PERF_EN, all perf counters read 0.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard unit: forward-select encodings and the
// divide sequencer state encoding.
package hazard_pkg;

    // Forward-select encodings for the E-stage operand muxes.
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // Width of the optional performance counters.
    localparam int PERF_W = 32;

    // Divide sequencer states.
    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/hazard_div_seq.sv
// Multi-cycle divide sequencer: IDLE -> BUSY (DIV_LAT cycles) -> DONE.
// divbusy and divdoneE are registered copies of the BUSY and DONE states, so
// together they expose the full FSM state (neither set means IDLE).
// An exception in M aborts the sequence from any state.
module hazard_div_seq
    import hazard_pkg::*;
#(
    parameter int DIV_LAT = 32,
    parameter int CW      = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic divE,
    input  logic exceptM,
    input  logic memstallM,
    output logic divstall,
    output logic divbusy,
    output logic divdoneE
);

    localparam logic [CW-1:0] CNT_LOAD = CW'(DIV_LAT - 1);

    div_state_t    state;
    logic [CW-1:0] cnt;

    // State, latency counter and registered status flags. The counter keeps
    // running while memory stalls; only the DONE state waits for memory.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= DIV_IDLE;
            cnt      <= '0;
            divbusy  <= 1'b0;
            divdoneE <= 1'b0;
        end else if (exceptM) begin
            state    <= DIV_IDLE;
            cnt      <= '0;
            divbusy  <= 1'b0;
            divdoneE <= 1'b0;
        end else begin
            case (state)
                DIV_IDLE: begin
                    if (divE) begin
                        state   <= DIV_BUSY;
                        cnt     <= CNT_LOAD;
                        divbusy <= 1'b1;
                    end
                end
                DIV_BUSY: begin
                    if (cnt == '0) begin
                        state    <= DIV_DONE;
                        divbusy  <= 1'b0;
                        divdoneE <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DIV_DONE: begin
                    if (!memstallM) begin
                        state    <= DIV_IDLE;
                        divdoneE <= 1'b0;
                    end
                end
                default: begin
                    state    <= DIV_IDLE;
                    cnt      <= '0;
                    divbusy  <= 1'b0;
                    divdoneE <= 1'b0;
                end
            endcase
        end
    end

    // Stall from the cycle a divide is first seen in E until the last BUSY cycle.
    assign divstall = ((state == DIV_IDLE) && divE && !exceptM) || (state == DIV_BUSY);

endmodule

// File: rtl/hazard_sb.sv
// Five-stage pipeline hazard unit: combinational forwarding, load-use and
// divide stalls, memory-wait stalls and precise exception flush.
// Optional build macro HAZARD_PERF_EN adds saturating per-cause cycle counters.
module hazard_sb
    import hazard_pkg::*;
#(
    parameter int AW      = 5,
    parameter int DIV_LAT = 32,
    parameter int CW      = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] rsD,
    input  logic [AW-1:0] rtD,
    input  logic          branchD,
    input  logic [AW-1:0] rsE,
    input  logic [AW-1:0] rtE,
    input  logic [AW-1:0] writeregE,
    input  logic          regwriteE,
    input  logic          memtoregE,
    input  logic          divE,
    input  logic [AW-1:0] writeregM,
    input  logic          regwriteM,
    input  logic          memtoregM,
    input  logic          jumpbranchM,
    input  logic          memstallM,
    input  logic          exceptM,
    input  logic [AW-1:0] writeregW,
    input  logic          regwriteW,
    output logic          forwardaD,
    output logic          forwardbD,
    output logic [1:0]    forwardaE,
    output logic [1:0]    forwardbE,
    output logic          stallF,
    output logic          stallD,
    output logic          stallE,
    output logic          stallM,
    output logic          stallW,
    output logic          flushF,
    output logic          flushD,
    output logic          flushE,
    output logic          flushM,
    output logic          flushW,
    output logic          divbusy,
    output logic          divdoneE
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]   perf_lw,
    output logic [31:0]   perf_div,
    output logic [31:0]   perf_mem,
    output logic [31:0]   perf_flush
`endif
);

    logic divstall;
    logic lwstall;

    // branchD only qualifies when the D-stage forwards are consumed and
    // memtoregM is covered by the load-use stall in E; neither changes the
    // equations here.
    logic unused_ok;
    assign unused_ok = branchD ^ memtoregM;

    hazard_div_seq #(
        .DIV_LAT (DIV_LAT),
        .CW      (CW)
    ) u_div_seq (
        .clk       (clk),
        .rst       (rst),
        .divE      (divE),
        .exceptM   (exceptM),
        .memstallM (memstallM),
        .divstall  (divstall),
        .divbusy   (divbusy),
        .divdoneE  (divdoneE)
    );

    // E-stage operand select: M beats W; register 0 never forwards.
    function automatic logic [1:0] fwd_sel(input logic [AW-1:0] idx,
                                           input logic [AW-1:0] wm, input logic rwm,
                                           input logic [AW-1:0] ww, input logic rww);
        if ((idx != '0) && rwm && (idx == wm))      return FWD_MEM;
        else if ((idx != '0) && rww && (idx == ww)) return FWD_WB;
        else                                        return FWD_RF;
    endfunction

    // Forward selects for the D-stage branch compare and the E-stage ALU.
    always_comb begin
        forwardaD = (rsD != '0) && (rsD == writeregM) && regwriteM;
        forwardbD = (rtD != '0) && (rtD == writeregM) && regwriteM;
        forwardaE = fwd_sel(rsE, writeregM, regwriteM, writeregW, regwriteW);
        forwardbE = fwd_sel(rtE, writeregM, regwriteM, writeregW, regwriteW);
    end

    // Load in E whose destination is a D-stage source must hold D for a cycle.
    assign lwstall = memtoregE && regwriteE && (writeregE != '0) &&
                     ((writeregE == rsD) || (writeregE == rtD));

    // Stall/flush by priority: exception, memory wait, divide, load-use, redirect.
    always_comb begin
        stallF = 1'b0;
        stallD = 1'b0;
        stallE = 1'b0;
        stallM = 1'b0;
        flushF = 1'b0;
        flushD = 1'b0;
        flushE = 1'b0;
        flushM = 1'b0;
        flushW = 1'b0;
        if (exceptM) begin
            flushF = 1'b1;
            flushD = 1'b1;
            flushE = 1'b1;
            flushM = 1'b1;
        end else if (memstallM) begin
            stallF = 1'b1;
            stallD = 1'b1;
            stallE = 1'b1;
            stallM = 1'b1;
            flushW = 1'b1;
        end else if (divstall) begin
            stallF = 1'b1;
            stallD = 1'b1;
            stallE = 1'b1;
            flushM = 1'b1;
            // The divide stays in E, so a redirect only squashes F and D.
            flushF = jumpbranchM;
            flushD = jumpbranchM;
        end else if (lwstall) begin
            stallF = 1'b1;
            stallD = 1'b1;
            flushE = 1'b1;
            flushD = jumpbranchM;
        end else if (jumpbranchM) begin
            flushF = 1'b1;
            flushD = 1'b1;
            flushE = 1'b1;
        end
    end

    // Writeback never stalls.
    assign stallW = 1'b0;

`ifdef HAZARD_PERF_EN
    logic win_mem;
    logic win_div;
    logic win_lw;
    logic win_flush;

    assign win_mem   = !exceptM && memstallM;
    assign win_div   = !exceptM && !memstallM && divstall;
    assign win_lw    = !exceptM && !memstallM && !divstall && lwstall;
    // Flush cause: an exception, or a redirect with no stall cause above it.
    assign win_flush = exceptM ||
                       (!memstallM && !divstall && !lwstall && jumpbranchM);

    // Saturating per-cause cycle counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_lw    <= '0;
            perf_div   <= '0;
            perf_mem   <= '0;
            perf_flush <= '0;
        end else begin
            if (win_lw    && (perf_lw    != '1)) perf_lw    <= perf_lw    + 1'b1;
            if (win_div   && (perf_div   != '1)) perf_div   <= perf_div   + 1'b1;
            if (win_mem   && (perf_mem   != '1)) perf_mem   <= perf_mem   + 1'b1;
            if (win_flush && (perf_flush != '1)) perf_flush <= perf_flush + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_sb.sv
// Randomised and directed bench for hazard_sb. The driver pushes the expected
// output vector for every cycle; a negedge monitor pops and compares.
// Build with HAZARD_PERF_EN to also check the performance counters.
module tb_hazard_sb;

    localparam int AW  = 5;
    localparam int LAT = 4;
    localparam int W   = 18;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
    logic          branchD, regwriteE, memtoregE, divE;
    logic          regwriteM, memtoregM, jumpbranchM, memstallM, exceptM, regwriteW;
    logic          forwardaD, forwardbD;
    logic [1:0]    forwardaE, forwardbE;
    logic          stallF, stallD, stallE, stallM, stallW;
    logic          flushF, flushD, flushE, flushM, flushW;
    logic          divbusy, divdoneE;
`ifdef HAZARD_PERF_EN
    logic [31:0]   perf_lw, perf_div, perf_mem, perf_flush;
    int            ep_lw, ep_div, ep_mem, ep_flush;
`endif

    hazard_sb #(.AW(AW), .DIV_LAT(LAT), .CW(8)) dut (
        .clk(clk), .rst(rst),
        .rsD(rsD), .rtD(rtD), .branchD(branchD),
        .rsE(rsE), .rtE(rtE), .writeregE(writeregE),
        .regwriteE(regwriteE), .memtoregE(memtoregE), .divE(divE),
        .writeregM(writeregM), .regwriteM(regwriteM), .memtoregM(memtoregM),
        .jumpbranchM(jumpbranchM), .memstallM(memstallM), .exceptM(exceptM),
        .writeregW(writeregW), .regwriteW(regwriteW),
        .forwardaD(forwardaD), .forwardbD(forwardbD),
        .forwardaE(forwardaE), .forwardbE(forwardbE),
        .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM), .stallW(stallW),
        .flushF(flushF), .flushD(flushD), .flushE(flushE), .flushM(flushM), .flushW(flushW),
        .divbusy(divbusy), .divdoneE(divdoneE)
`ifdef HAZARD_PERF_EN
        , .perf_lw(perf_lw), .perf_div(perf_div), .perf_mem(perf_mem), .perf_flush(perf_flush)
`endif
    );

    // Clock.
    always #5 clk = ~clk;

    // Scoreboard state.
    logic [W-1:0] exp_q[$];
    int           cyc_q[$];
    int           total = 0;
    int           bad   = 0;
    int           cyc   = 0;

    // Reference model of the divider: the cycle a divide started, and whether
    // a finished result is waiting to be consumed.
    bit m_started = 1'b0;
    bit m_done    = 1'b0;
    int m_start   = 0;

    task automatic clear_inputs();
        rsD = '0; rtD = '0; branchD = 1'b0;
        rsE = '0; rtE = '0; writeregE = '0; regwriteE = 1'b0; memtoregE = 1'b0; divE = 1'b0;
        writeregM = '0; regwriteM = 1'b0; memtoregM = 1'b0;
        jumpbranchM = 1'b0; memstallM = 1'b0; exceptM = 1'b0;
        writeregW = '0; regwriteW = 1'b0;
    endtask

    function automatic logic [1:0] exp_fwd(input logic [AW-1:0] idx);
        if (idx != 0 && regwriteM && idx == writeregM) return 2'b10;
        if (idx != 0 && regwriteW && idx == writeregW) return 2'b01;
        return 2'b00;
    endfunction

    // Compute this cycle's expected outputs, queue them, advance the model,
    // then move to just after the next rising edge.
    task automatic tick();
        logic [W-1:0] e;
        logic [4:0]   st, fl;
        logic         fad, fbd, lw, busy_now, done_now, idle_now, dstall;
        int           win;
        fad = (rsD != 0) && (rsD == writeregM) && regwriteM;
        fbd = (rtD != 0) && (rtD == writeregM) && regwriteM;
        lw  = memtoregE && regwriteE && (writeregE != 0) &&
              ((writeregE == rsD) || (writeregE == rtD));
        busy_now = m_started && (cyc > m_start) && (cyc <= m_start + LAT);
        done_now = m_done;
        idle_now = !busy_now && !done_now;
        dstall   = busy_now || (idle_now && divE && !exceptM);
        // Bits ordered F D E M W, F in the MSB.
        st = 5'b0; fl = 5'b0; win = 0;
        if (exceptM) begin
            fl = 5'b11110; win = 1;
        end else if (memstallM) begin
            st = 5'b11110; fl = 5'b00001; win = 2;
        end else if (dstall) begin
            st = 5'b11100; fl = 5'b00010; win = 3;
            if (jumpbranchM) fl = fl | 5'b11000;
        end else if (lw) begin
            st = 5'b11000; fl = 5'b00100; win = 4;
            if (jumpbranchM) fl = fl | 5'b01000;
        end else if (jumpbranchM) begin
            fl = 5'b11100; win = 5;
        end
        e = {fad, fbd, exp_fwd(rsE), exp_fwd(rtE), st, fl, busy_now, done_now};
        exp_q.push_back(e);
        cyc_q.push_back(cyc);
`ifdef HAZARD_PERF_EN
        if (rst) begin
            ep_lw = 0; ep_div = 0; ep_mem = 0; ep_flush = 0;
        end else begin
            if (win == 4) ep_lw++;
            if (win == 3) ep_div++;
            if (win == 2) ep_mem++;
            if (win == 1 || win == 5) ep_flush++;
        end
`endif
        if (rst || exceptM) begin
            m_started = 1'b0; m_done = 1'b0;
        end else if (idle_now && divE) begin
            m_started = 1'b1; m_start = cyc;
        end else if (busy_now && cyc == m_start + LAT) begin
            m_started = 1'b0; m_done = 1'b1;
        end else if (done_now && !memstallM) begin
            m_done = 1'b0;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

`ifdef HAZARD_PERF_EN
    task automatic check_perf(input string tag);
        total++;
        if (perf_lw !== 32'(ep_lw) || perf_div !== 32'(ep_div) ||
            perf_mem !== 32'(ep_mem) || perf_flush !== 32'(ep_flush)) begin
            bad++;
            $display("FAIL perf_%s got lw=%0d div=%0d mem=%0d flush=%0d exp lw=%0d div=%0d mem=%0d flush=%0d",
                     tag, perf_lw, perf_div, perf_mem, perf_flush, ep_lw, ep_div, ep_mem, ep_flush);
        end
    endtask
`endif

    // Monitor: every cycle the DUT presents a full output vector.
    always @(negedge clk) begin
        logic [W-1:0] act, e;
        int           c;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            c = cyc_q.pop_front();
            act = {forwardaD, forwardbD, forwardaE, forwardbE,
                   stallF, stallD, stallE, stallM, stallW,
                   flushF, flushD, flushE, flushM, flushW, divbusy, divdoneE};
            total++;
            if (act !== e) begin
                bad++;
                $display("FAIL outs cyc=%0d got=%05h exp=%05h", c, act, e);
            end
        end
    end

    // Stimulus.
    initial begin
        clear_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Reset state of the sequencer flags.
        total++;
        if (divbusy !== 1'b0 || divdoneE !== 1'b0) begin
            bad++;
            $display("FAIL reset_flags got busy=%b done=%b exp busy=0 done=0", divbusy, divdoneE);
        end
        tick();
        rst = 1'b0;
`ifdef HAZARD_PERF_EN
        check_perf("after_reset");
`endif

        // Forwarding: M beats W; register 0 never forwards.
        regwriteM = 1'b1; writeregM = 5'd8; rsE = 5'd8;
        regwriteW = 1'b1; writeregW = 5'd8; rtE = 5'd8;
        tick();
        writeregM = 5'd0; rsE = 5'd0;
        tick();
        regwriteM = 1'b0; writeregM = 5'd3; rsD = 5'd3; rtE = 5'd8;
        tick();
        clear_inputs();

        // Load-use stall, then destination zero.
        memtoregE = 1'b1; regwriteE = 1'b1; writeregE = 5'd9; rtD = 5'd9;
        tick();
        jumpbranchM = 1'b1;
        tick();
        jumpbranchM = 1'b0; writeregE = 5'd0; rtD = 5'd0;
        tick();
        clear_inputs();
        tick();

        // Full divide with a redirect during the stall.
        divE = 1'b1;
        for (int i = 0; i <= LAT; i++) begin
            jumpbranchM = (i == 2);
            tick();
        end
        divE = 1'b0; jumpbranchM = 1'b0;
        repeat (3) tick();

        // Divide aborted by an exception two cycles in.
        divE = 1'b1;
        tick();
        tick();
        exceptM = 1'b1;
        tick();
        exceptM = 1'b0; divE = 1'b0;
        repeat (LAT + 3) tick();

        // Memory wait while the result is ready: DONE holds, no restart.
        divE = 1'b1;
        for (int i = 0; i <= LAT; i++) tick();
        divE = 1'b0; memstallM = 1'b1;
        repeat (3) tick();
        memstallM = 1'b0;
        repeat (3) tick();

        // Memory wait in the middle of BUSY does not pause the counter.
        divE = 1'b1;
        tick();
        memstallM = 1'b1;
        repeat (2) tick();
        memstallM = 1'b0;
        repeat (LAT) tick();
        divE = 1'b0;
        repeat (2) tick();

        // Reset in the middle of BUSY.
        divE = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; divE = 1'b0;
`ifdef HAZARD_PERF_EN
        check_perf("mid_reset");
`endif
        repeat (2) tick();

        // Random traffic; small index range so matches are common.
        for (int n = 0; n < 3000; n++) begin
            rsD = AW'($urandom_range(0, 3));
            rtD = AW'($urandom_range(0, 3));
            rsE = AW'($urandom_range(0, 3));
            rtE = AW'($urandom_range(0, 3));
            writeregE = AW'($urandom_range(0, 3));
            writeregM = AW'($urandom_range(0, 3));
            writeregW = AW'($urandom_range(0, 3));
            branchD     = 1'($urandom_range(0, 1));
            regwriteE   = 1'($urandom_range(0, 1));
            memtoregE   = 1'($urandom_range(0, 1));
            regwriteM   = 1'($urandom_range(0, 1));
            memtoregM   = 1'($urandom_range(0, 1));
            regwriteW   = 1'($urandom_range(0, 1));
            divE        = ($urandom_range(0, 5) == 0);
            jumpbranchM = ($urandom_range(0, 4) == 0);
            memstallM   = ($urandom_range(0, 5) == 0);
            exceptM     = ($urandom_range(0, 29) == 0);
            rst         = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst = 1'b0;
        clear_inputs();
        tick();

        // Drain: the monitor pops at the next falling edge.
        for (int w = 0; w < 4 && exp_q.size() > 0; w++) @(negedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain got=%0d pending exp=0", exp_q.size());
        end
`ifdef HAZARD_PERF_EN
        check_perf("final");
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
